// File: rtl/sale_input_conditioner_if.sv
// Board-side bundle of the sale terminal input conditioner: raw SW/KEY in, conditioned levels and strobes out.
// Latency: none, wires only. Backpressure: none, levels and single-cycle strobes.
// master = conditioner side, slave = board/consumer side.
interface sale_input_conditioner_if;
    logic [2:0] SW;
    logic [3:0] KEY;
    logic [2:0] CleanSWOut;
    logic [3:0] KEY_Reg;
    logic       KEY_Pulse;
    logic [3:0] CMD_Reg;
    logic       CMD_Valid;

    modport master (
        input  SW, KEY,
        output CleanSWOut, KEY_Reg, KEY_Pulse, CMD_Reg, CMD_Valid
    );

    modport slave (
        output SW, KEY,
        input  CleanSWOut, KEY_Reg, KEY_Pulse, CMD_Reg, CMD_Valid
    );
endinterface

// File: rtl/sale_input_conditioner.sv
// Syncs and debounces SW/KEY, detects key presses and assembles two-key commands into CMD_Reg.
// Latency: DEBOUNCE_CYCLES+2 edges to CleanSWOut, +3 to press outputs (2/3 edges with DEBOUNCE_BYPASS_EN).
// Backpressure: none; strobes are single-cycle and consumers must sample them.
module sale_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    sale_input_conditioner_if.master   io
);

    // KEY and SW are handled as one 7-bit vector {KEY, SW}; KEY idles high.
    localparam int         NB      = 7;
    localparam logic [6:0] RST_VAL = 7'b1111_000;

    typedef enum logic [1:0] {
        CMD_IDLE,
        CMD_HALF,
        CMD_FULL
    } cmd_state_e;

    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] stable;

    always_comb begin
        sync1_d = {io.KEY, io.SW};
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef DEBOUNCE_BYPASS_EN
    assign stable = sync2_q;
`else
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    logic [NB-1:0]    stable_q, stable_d;

    // A bit is accepted only after it has differed for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            stable_q <= RST_VAL;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign stable = stable_q;
`endif

    logic [3:0]  key_prev_q, key_prev_d;
    logic [3:0]  key_reg_q, key_reg_d;
    logic        key_pulse_q, key_pulse_d;
    logic [3:0]  cmd_reg_q, cmd_reg_d;
    logic        cmd_vld_q, cmd_vld_d;
    cmd_state_e  state_q, state_d;

    logic [3:0]  press;
    logic        press_any;
    logic [1:0]  press_idx;
    logic        cmd_mode;

    assign press    = key_prev_q & ~stable[6:3];
    assign cmd_mode = stable[0];

    always_comb begin
        key_prev_d  = stable[6:3];
        press_any   = |press;
        press_idx   = 2'd0;
        // Descending scan so the lowest pressed index is the one kept.
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) press_idx = 2'(i);
        end
        key_pulse_d = press_any;
        key_reg_d   = key_reg_q;
        if (press_any) key_reg_d = 4'b0001 << press_idx;
    end

    always_comb begin
        state_d   = state_q;
        cmd_reg_d = cmd_reg_q;
        cmd_vld_d = 1'b0;
        if (!cmd_mode) begin
            state_d   = CMD_IDLE;
            cmd_reg_d = 4'b0000;
        end else if (press_any) begin
            case (state_q)
                CMD_HALF: begin
                    state_d   = CMD_FULL;
                    cmd_reg_d = {cmd_reg_q[1:0], press_idx};
                    cmd_vld_d = 1'b1;
                end
                default: begin
                    state_d   = CMD_HALF;
                    cmd_reg_d = {2'b00, press_idx};
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            key_prev_q  <= 4'b1111;
            key_reg_q   <= 4'b0000;
            key_pulse_q <= 1'b0;
            cmd_reg_q   <= 4'b0000;
            cmd_vld_q   <= 1'b0;
            state_q     <= CMD_IDLE;
        end else begin
            key_prev_q  <= key_prev_d;
            key_reg_q   <= key_reg_d;
            key_pulse_q <= key_pulse_d;
            cmd_reg_q   <= cmd_reg_d;
            cmd_vld_q   <= cmd_vld_d;
            state_q     <= state_d;
        end
    end

    assign io.CleanSWOut = stable[2:0];
    assign io.KEY_Reg    = key_reg_q;
    assign io.KEY_Pulse  = key_pulse_q;
    assign io.CMD_Reg    = cmd_reg_q;
    assign io.CMD_Valid  = cmd_vld_q;

endmodule

// File: tb/tb_sale_input_conditioner.sv
// Directed bench for sale_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
// Inputs change 1 time unit after a rising edge; "edge N" counts rising edges from that change.
module tb_sale_input_conditioner;

    logic CLOCK_50;
    logic RESET_N;
    int   n_chk;
    int   n_err;

    sale_input_conditioner_if bus ();

    sale_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .io       (bus.master)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Advance n edges, counting KEY_Pulse and CMD_Valid strobes seen after each edge.
    task automatic tick_count(input int n, output int pulses, output int valids);
        pulses = 0;
        valids = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.KEY_Pulse) pulses++;
            if (bus.CMD_Valid) valids++;
        end
    endtask

    task automatic clean_reset();
        bus.SW   = 3'b000;
        bus.KEY  = 4'b1111;
        RESET_N  = 1'b0;
        tick(2);
        RESET_N  = 1'b1;
        tick(2);
    endtask

    // Press and hold one key; returns right after the edge the press is reported on (edge 7).
    task automatic press_key(input int idx);
        bus.KEY      = 4'b1111;
        bus.KEY[idx] = 1'b0;
        tick(7);
    endtask

    task automatic release_keys();
        int p, v;
        bus.KEY = 4'b1111;
        tick_count(10, p, v);
        check("release_no_pulse", p, 0);
    endtask

    initial begin
        int p, v;
        n_chk = 0;
        n_err = 0;

        // Reset held with all inputs active.
        RESET_N = 1'b0;
        bus.SW  = 3'b111;
        bus.KEY = 4'b0000;
        tick(3);
        check("rst_clean_sw",  bus.CleanSWOut, 3'b000);
        check("rst_key_reg",   bus.KEY_Reg,    4'b0000);
        check("rst_key_pulse", bus.KEY_Pulse,  1'b0);
        check("rst_cmd_reg",   bus.CMD_Reg,    4'b0000);
        check("rst_cmd_valid", bus.CMD_Valid,  1'b0);
        RESET_N = 1'b1;
        tick(5);
        check("rel_sw_edge5", bus.CleanSWOut, 3'b000);
        tick(1);
        check("rel_sw_edge6", bus.CleanSWOut, 3'b111);
        // All four keys fall together: lowest index reported.
        tick(1);
        check("rel_all_keys_pulse", bus.KEY_Pulse, 1'b1);
        check("rel_all_keys_reg",   bus.KEY_Reg,   4'b0001);

        // Glitch rejection: 3-cycle pulse on SW[1].
        clean_reset();
        bus.SW = 3'b010;
        tick(3);
        bus.SW = 3'b000;
        p = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.CleanSWOut != 3'b000) p++;
        end
        check("glitch_rejected", p, 0);
        bus.SW = 3'b010;
        tick(5);
        check("sw1_edge5", bus.CleanSWOut, 3'b000);
        tick(1);
        check("sw1_edge6", bus.CleanSWOut, 3'b010);
        bus.SW = 3'b000;
        tick(8);

        // Single press, command mode off.
        bus.KEY = 4'b1011;
        tick(6);
        check("k2_edge6_pulse", bus.KEY_Pulse, 1'b0);
        tick(1);
        check("k2_edge7_pulse", bus.KEY_Pulse, 1'b1);
        check("k2_edge7_reg",   bus.KEY_Reg,   4'b0100);
        check("k2_cmd_off",     bus.CMD_Reg,   4'b0000);
        tick(1);
        check("k2_edge8_pulse", bus.KEY_Pulse, 1'b0);
        release_keys();
        check("k2_reg_held", bus.KEY_Reg, 4'b0100);

        // Two-key command.
        bus.SW = 3'b001;
        tick(8);
        check("cmd_mode_on", bus.CleanSWOut, 3'b001);
        press_key(3);
        check("cmd1_reg",   bus.CMD_Reg,   4'b0011);
        check("cmd1_valid", bus.CMD_Valid, 1'b0);
        check("cmd1_key",   bus.KEY_Reg,   4'b1000);
        release_keys();
        press_key(1);
        check("cmd2_reg",   bus.CMD_Reg,   4'b1101);
        check("cmd2_valid", bus.CMD_Valid, 1'b1);
        tick(1);
        check("cmd2_valid_1cyc", bus.CMD_Valid, 1'b0);
        release_keys();
        press_key(0);
        check("cmd3_reg",   bus.CMD_Reg,   4'b0000);
        check("cmd3_valid", bus.CMD_Valid, 1'b0);
        release_keys();
        press_key(2);
        check("cmd4_reg",   bus.CMD_Reg,   4'b0010);
        check("cmd4_valid", bus.CMD_Valid, 1'b1);
        release_keys();

        // Simultaneous KEY[1] and KEY[2] as the first key of a new command.
        bus.KEY = 4'b1001;
        tick_count(12, p, v);
        check("simul_one_pulse", p, 1);
        check("simul_key_reg",   bus.KEY_Reg, 4'b0010);
        check("simul_cmd_reg",   bus.CMD_Reg, 4'b0001);
        release_keys();

        // Second press accepted together with command mode falling.
        bus.SW  = 3'b000;
        bus.KEY = 4'b1110;
        tick(6);
        check("modefall_edge6_sw",  bus.CleanSWOut, 3'b000);
        check("modefall_edge6_cmd", bus.CMD_Reg,    4'b0001);
        tick(1);
        check("modefall_pulse", bus.KEY_Pulse, 1'b1);
        check("modefall_cmd",   bus.CMD_Reg,   4'b0000);
        check("modefall_valid", bus.CMD_Valid, 1'b0);
        check("modefall_key",   bus.KEY_Reg,   4'b0001);
        release_keys();

        // Mid-operation reset: in CMD_HALF with a KEY[3] debounce count running.
        bus.SW = 3'b001;
        tick(8);
        press_key(2);
        check("mid_half_cmd", bus.CMD_Reg, 4'b0010);
        release_keys();
        bus.KEY = 4'b0111;
        tick(3);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_sw",  bus.CleanSWOut, 3'b000);
        check("mid_rst_key", bus.KEY_Reg,    4'b0000);
        check("mid_rst_cmd", bus.CMD_Reg,    4'b0000);
        @(posedge CLOCK_50);
        #1;
        RESET_N = 1'b1;
        tick_count(6, p, v);
        check("mid_no_early_pulse", p, 0);
        check("mid_sw_edge6", bus.CleanSWOut, 3'b001);
        tick(1);
        check("mid_pulse_edge7", bus.KEY_Pulse, 1'b1);
        check("mid_key_edge7",   bus.KEY_Reg,   4'b1000);
        check("mid_cmd_edge7",   bus.CMD_Reg,   4'b0011);
        check("mid_valid_edge7", bus.CMD_Valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sale_input_conditioner.md
# sale_input_conditioner

Conditions the raw slide switches and pushbuttons of the sale terminal and produces the registered signals consumed by the LED controller and the main control FSM. It has two halves. The first synchronises and debounces SW[2:0] into CleanSWOut and KEY[3:0] into a clean active-low level. The second detects key presses and assembles two-key command codes into CMD_Reg whenever command mode (CleanSWOut[0]) is active. It sits directly between the board I/O pins and the LED controller and state logic.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new input level (10 ms at 50 MHz); minimum 2.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SW  in  3  raw slide switches; asynchronous to the clock.
- KEY  in  4  raw pushbuttons, active-low (0 = pressed); asynchronous to the clock.
- CleanSWOut  out  3  debounced switch levels; bit 0 = command mode.
- KEY_Reg  out  4  one-hot code of the most recently pressed key, held until the next press.
- KEY_Pulse  out  1  single-cycle strobe on each accepted press.
- CMD_Reg  out  4  command code {first_key_idx[1:0], second_key_idx[1:0]}.
- CMD_Valid  out  1  single-cycle strobe when a two-key command is complete.

## Operation
- Synchroniser: each input bit passes through two flops. SW flops reset to 0; KEY flops reset to 1.
- Debounce, per bit: an independent CNT_W counter.
  - Counter clears whenever the synchronised bit equals the stable bit.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while the bits still differ, the stable bit takes the new value on the next edge and the counter clears.
  - Any return to the stable level before that point clears the counter, so the glitch is rejected.
- Stable reset values: SW stable = 3'b000; KEY stable = 4'b1111.
- Press event: the stable KEY bit falls from 1 to 0. Releases generate no event.
- On a press event:
  - KEY_Reg <= one-hot of the key index.
  - KEY_Pulse = 1 for exactly one cycle.
  - If several keys have press events in the same cycle, the lowest index wins and the others are dropped.
- Command FSM, states CMD_IDLE, CMD_HALF and CMD_FULL; updated only when CleanSWOut[0] = 1:
  - CMD_IDLE + press → CMD_HALF, CMD_Reg <= {2'b00, idx}.
  - CMD_HALF + press → CMD_FULL, CMD_Reg <= {CMD_Reg[1:0], idx}, CMD_Valid = 1 for one cycle.
  - CMD_FULL + press → CMD_HALF, CMD_Reg <= {2'b00, idx}; this starts a new command.
- CleanSWOut[0] = 0: the FSM is forced to CMD_IDLE and CMD_Reg is cleared to 0.
  - This clear has priority over a press event in the same cycle; no CMD_Valid is produced in that case.
  - KEY_Reg and KEY_Pulse still update normally.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
- Reset values of all outputs: CleanSWOut = 0, KEY_Reg = 0, KEY_Pulse = 0, CMD_Reg = 0, CMD_Valid = 0, FSM = CMD_IDLE.
- Reset is asynchronous: it takes effect immediately, including in the middle of debounce or in the middle of a command. All counters clear.
- Synchroniser latency: 2 edges from raw input change to synchronised change.
- Debounce latency: the stable/CleanSWOut update occurs DEBOUNCE_CYCLES edges after the synchronised bit first differs. Total = DEBOUNCE_CYCLES + 2 edges from the raw change.
- KEY_Pulse, KEY_Reg, CMD_Reg and CMD_Valid update on the edge after the stable KEY bit falls, i.e. DEBOUNCE_CYCLES + 3 edges after the raw press.
- Command mode is sampled from the registered CleanSWOut[0] in the same cycle as the press event.
- Strobes never last more than 1 cycle. With DEBOUNCE_CYCLES ≥ 2, the minimum spacing between KEY_Pulse strobes is 2 × DEBOUNCE_CYCLES cycles (press and release must both be accepted).

## Configuration
- DEBOUNCE_BYPASS_EN defined:
  - Debounce counters are removed.
  - Stable bits = synchroniser outputs, so input-to-stable latency is 2 edges.
  - Press/command latency is 3 edges.
  - The DEBOUNCE_CYCLES and CNT_W parameters are ignored.
  - For fast simulation only.
- DEBOUNCE_BYPASS_EN undefined: full debounce as described above. This is the synthesis default.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, CNT_W = 3, macro undefined.
- Reset check: hold RESET_N = 0 for 3 cycles with SW = 3'b111, KEY = 4'b0000 → all outputs 0. After release, CleanSWOut = 3'b111 at edge 6.
- Glitch rejection: SW[1] pulses high for 3 cycles → CleanSWOut stays 0. The same pulse held for 6 cycles → CleanSWOut[1] = 1 exactly 6 edges after the rising raw edge.
- Single press, command mode off: KEY[2] driven low and held → KEY_Reg = 4'b0100 and a one-cycle KEY_Pulse at edge 7; CMD_Reg remains 0; release → no pulse.
- Two-key command: CleanSWOut[0] = 1; press KEY[3], release, then press KEY[1] → CMD_Reg = 4'b0011 after the first press, then 4'b1101 with CMD_Valid = 1 for one cycle; a third press of KEY[0] → CMD_Reg = 4'b0000 in state CMD_HALF, no CMD_Valid.
- Simultaneous events: KEY[1] and KEY[2] pressed on the same raw edge → KEY_Reg = 4'b0010, only one KEY_Pulse. A press accepted on the same edge that CleanSWOut[0] falls → CMD_Reg = 0, CMD_Valid = 0, KEY_Pulse = 1.
- Mid-operation reset: assert RESET_N = 0 in CMD_HALF with a debounce count in progress → outputs 0 immediately. After release, the key held low is re-accepted only after the full 6-edge latency.
